// File: rtl/twdl_pkg.sv
// twdl_pkg: shared constants and types for the twiddle-aligned complex multiplier.
package twdl_pkg;

    localparam int TWDL_LAT    = 24;   // CORDIC generator latency in clk cycles
    localparam int TWDL_FRAC   = 14;   // twiddle unity = 2**TWDL_FRAC
    localparam int W_TWDL_DATA = 16;   // default data/twiddle width

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    // Control bits that travel alongside each data sample.
    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic sel3;
    } twdl_ctl_t;

endpackage

// File: rtl/cmult_pipe.sv
// cmult_pipe: 3-stage complex multiply with round-half-up and narrowing.
//   S1 products, S2 cross-add plus rounding constant, S3 shift and narrow.
// TWDL_CMULT_SAT_EN defined: S3 saturates and reports clamps on sat_o.
// TWDL_CMULT_SAT_EN undefined: S3 wraps and sat_o does not exist.
module cmult_pipe
    import twdl_pkg::*;
#(
    parameter int W_DATA    = W_TWDL_DATA,
    parameter int W_TWDL    = W_TWDL_DATA,
    parameter int TWDL_FRAC = twdl_pkg::TWDL_FRAC
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [W_DATA-1:0] a_re_i,
    input  logic signed [W_DATA-1:0] a_im_i,
    input  logic signed [W_TWDL-1:0] b_re_i,
    input  logic signed [W_TWDL-1:0] b_im_i,
    output logic signed [W_DATA-1:0] re_o,
    output logic signed [W_DATA-1:0] im_o
`ifdef TWDL_CMULT_SAT_EN
    ,
    output logic                     sat_o
`endif
);

    localparam int W_P = W_DATA + W_TWDL;   // full product width
    localparam int W_S = W_P + 1;           // one guard bit for the cross sum
    localparam logic signed [W_S-1:0] RND = W_S'(2 ** (TWDL_FRAC - 1));

    logic signed [W_P-1:0]    ac_q, bd_q, ad_q, bc_q;
    logic signed [W_S-1:0]    re_q, im_q;
    logic signed [W_DATA-1:0] re_d, im_d;

`ifdef TWDL_CMULT_SAT_EN
    localparam logic signed [W_S-1:0] MAXV = W_S'(2 ** (W_DATA - 1) - 1);
    localparam logic signed [W_S-1:0] MINV = W_S'(-(2 ** (W_DATA - 1)));

    logic re_clamp, im_clamp;

    // Floor-shift then clamp into the output range, flagging any clamp.
    function automatic logic signed [W_DATA-1:0] narrow(input logic signed [W_S-1:0] v,
                                                        output logic clamp);
        logic signed [W_S-1:0] sh;
        sh    = v >>> TWDL_FRAC;
        clamp = 1'b0;
        if (sh > MAXV) begin
            narrow = MAXV[W_DATA-1:0];
            clamp  = 1'b1;
        end else if (sh < MINV) begin
            narrow = MINV[W_DATA-1:0];
            clamp  = 1'b1;
        end else begin
            narrow = sh[W_DATA-1:0];
        end
    endfunction
`else
    // Floor-shift then keep the low bits; out-of-range results wrap.
    function automatic logic signed [W_DATA-1:0] narrow(input logic signed [W_S-1:0] v);
        narrow = W_DATA'(v >>> TWDL_FRAC);
    endfunction
`endif

    // S1: four full-width products; data path registers carry no reset.
    always_ff @(posedge clk_i) begin
        ac_q <= W_P'(a_re_i) * W_P'(b_re_i);
        bd_q <= W_P'(a_im_i) * W_P'(b_im_i);
        ad_q <= W_P'(a_re_i) * W_P'(b_im_i);
        bc_q <= W_P'(a_im_i) * W_P'(b_re_i);
    end

    // S2: cross sums with the half-LSB rounding constant folded in.
    always_ff @(posedge clk_i) begin
        re_q <= W_S'(ac_q) - W_S'(bd_q) + RND;
        im_q <= W_S'(ad_q) + W_S'(bc_q) + RND;
    end

    // S3 combinational narrowing of the rounded sums.
    always_comb begin
`ifdef TWDL_CMULT_SAT_EN
        re_clamp = 1'b0;
        im_clamp = 1'b0;
        re_d = narrow(re_q, re_clamp);
        im_d = narrow(im_q, im_clamp);
`else
        re_d = narrow(re_q);
        im_d = narrow(im_q);
`endif
    end

    // S3 output registers; cleared on reset so the block powers up quiet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            re_o  <= '0;
            im_o  <= '0;
`ifdef TWDL_CMULT_SAT_EN
            sat_o <= 1'b0;
`endif
        end else begin
            re_o  <= re_d;
            im_o  <= im_d;
`ifdef TWDL_CMULT_SAT_EN
            sat_o <= re_clamp | im_clamp;
`endif
        end
    end

endmodule

// File: rtl/twdl_cmult_align.sv
// twdl_cmult_align: delays the data stream by the twiddle generator latency,
// picks the k=1 or k=3 twiddle and multiplies through cmult_pipe.
// Optional macro TWDL_CMULT_SAT_EN: saturate the product and keep a sticky ovf.
module twdl_cmult_align
    import twdl_pkg::*;
#(
    parameter int W_DATA    = W_TWDL_DATA,
    parameter int W_TWDL    = W_TWDL_DATA,
    parameter int TWDL_FRAC = twdl_pkg::TWDL_FRAC,
    parameter int TWDL_LAT  = twdl_pkg::TWDL_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic                     din_sop,
    input  logic                     din_eop,
    input  logic                     din_sel3,
    input  logic signed [W_DATA-1:0] din_real,
    input  logic signed [W_DATA-1:0] din_imag,
    input  logic signed [W_TWDL-1:0] tw1_real,
    input  logic signed [W_TWDL-1:0] tw1_imag,
    input  logic signed [W_TWDL-1:0] tw3_real,
    input  logic signed [W_TWDL-1:0] tw3_imag,
    output logic                     dout_valid,
    output logic                     dout_sop,
    output logic                     dout_eop,
    output logic signed [W_DATA-1:0] dout_real,
    output logic signed [W_DATA-1:0] dout_imag,
    output logic                     err_gap,
    output logic                     ovf
);

    localparam int MUL_STAGES = 3;

    twdl_ctl_t                ctl_q [TWDL_LAT];
    logic signed [W_DATA-1:0] dre_q [TWDL_LAT];
    logic signed [W_DATA-1:0] dim_q [TWDL_LAT];
    logic [MUL_STAGES-1:0]    vld_pipe_q, sop_pipe_q, eop_pipe_q;
    logic                     in_frame_q, err_gap_q;
    twdl_ctl_t                ctl_out;
    logic signed [W_TWDL-1:0] tw_re, tw_im;

    assign ctl_out = ctl_q[TWDL_LAT-1];

    // Control delay line; reset flushes every in-flight valid/sop/eop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TWDL_LAT; i++) ctl_q[i] <= '0;
        end else begin
            ctl_q[0] <= {din_valid, din_sop, din_eop, din_sel3};
            for (int i = 1; i < TWDL_LAT; i++) ctl_q[i] <= ctl_q[i-1];
        end
    end

    // Data delay line; advances every cycle regardless of din_valid.
    always_ff @(posedge clk) begin
        dre_q[0] <= din_real;
        dim_q[0] <= din_imag;
        for (int i = 1; i < TWDL_LAT; i++) begin
            dre_q[i] <= dre_q[i-1];
            dim_q[i] <= dim_q[i-1];
        end
    end

    // Live generator outputs pair with the sample leaving the delay line.
    always_comb begin
        tw_re = ctl_out.sel3 ? tw3_real : tw1_real;
        tw_im = ctl_out.sel3 ? tw3_imag : tw1_imag;
    end

`ifdef TWDL_CMULT_SAT_EN
    logic sat, ovf_q;
`endif

    cmult_pipe #(
        .W_DATA    (W_DATA),
        .W_TWDL    (W_TWDL),
        .TWDL_FRAC (TWDL_FRAC)
    ) u_cmult (
        .clk_i  (clk),
        .rst_i  (rst),
        .a_re_i (dre_q[TWDL_LAT-1]),
        .a_im_i (dim_q[TWDL_LAT-1]),
        .b_re_i (tw_re),
        .b_im_i (tw_im),
        .re_o   (dout_real),
        .im_o   (dout_imag)
`ifdef TWDL_CMULT_SAT_EN
        ,
        .sat_o  (sat)
`endif
    );

    // Control shadow of the multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
            eop_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[MUL_STAGES-2:0], ctl_out.valid};
            sop_pipe_q <= {sop_pipe_q[MUL_STAGES-2:0], ctl_out.sop};
            eop_pipe_q <= {eop_pipe_q[MUL_STAGES-2:0], ctl_out.eop};
        end
    end

    assign dout_valid = vld_pipe_q[MUL_STAGES-1];
    assign dout_sop   = sop_pipe_q[MUL_STAGES-1];
    assign dout_eop   = eop_pipe_q[MUL_STAGES-1];

    // Input-side frame tracker: eop wins over sop so a 1-sample frame never opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_q <= 1'b0;
            err_gap_q  <= 1'b0;
        end else if (din_valid) begin
            if (din_eop)      in_frame_q <= 1'b0;
            else if (din_sop) in_frame_q <= 1'b1;
        end else if (in_frame_q) begin
            err_gap_q <= 1'b1;
        end
    end

    assign err_gap = err_gap_q;

`ifdef TWDL_CMULT_SAT_EN
    // Sticky overflow, counted only when the clamped sample is a real output.
    always_ff @(posedge clk) begin
        if (rst)                     ovf_q <= 1'b0;
        else if (sat && dout_valid)  ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_twdl_cmult_align.sv
// tb_twdl_cmult_align: directed and randomized checks of twdl_cmult_align.
// Reference model works from a cycle-indexed history of the inputs.
module tb_twdl_cmult_align;

    localparam int LAT = 27;   // din -> dout
    localparam int TWO = 24;   // din -> twiddle pairing
    localparam int HN  = 4096;

    logic clk, rst;
    logic din_valid, din_sop, din_eop, din_sel3;
    logic signed [15:0] din_real, din_imag;
    logic signed [15:0] tw1_real, tw1_imag, tw3_real, tw3_imag;
    logic dout_valid, dout_sop, dout_eop, err_gap, ovf;
    logic signed [15:0] dout_real, dout_imag;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic               h_v [HN], h_s [HN], h_e [HN], h_sel [HN], h_rst [HN];
    logic signed [15:0] h_dr [HN], h_di [HN];
    logic signed [15:0] h_t1r [HN], h_t1i [HN], h_t3r [HN], h_t3i [HN];

    typedef struct packed { logic v; logic s; logic e; } stim_t;

    twdl_cmult_align dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_sel3(din_sel3),
        .din_real(din_real), .din_imag(din_imag),
        .tw1_real(tw1_real), .tw1_imag(tw1_imag), .tw3_real(tw3_real), .tw3_imag(tw3_imag),
        .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_real(dout_real), .dout_imag(dout_imag),
        .err_gap(err_gap), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what the DUT sampled at every rising edge.
    always @(posedge clk) begin
        if (cyc < HN) begin
            h_v[cyc]   <= din_valid;  h_s[cyc]   <= din_sop;  h_e[cyc] <= din_eop;
            h_sel[cyc] <= din_sel3;   h_rst[cyc] <= rst;
            h_dr[cyc]  <= din_real;   h_di[cyc]  <= din_imag;
            h_t1r[cyc] <= tw1_real;   h_t1i[cyc] <= tw1_imag;
            h_t3r[cyc] <= tw3_real;   h_t3i[cyc] <= tw3_imag;
        end
        cyc <= cyc + 1;
    end

    // Round half up, then saturate or wrap to 16 bits.
    function automatic logic signed [15:0] fix(input longint p, output logic clamp);
        longint r;
        clamp = 1'b0;
        r = (p + 8192) >>> 14;
`ifdef TWDL_CMULT_SAT_EN
        if (r > 32767)  begin clamp = 1'b1; return 16'sh7fff; end
        if (r < -32768) begin clamp = 1'b1; return 16'sh8000; end
`endif
        return 16'(r);
    endfunction

    // Expected outputs visible just after rising edge e.
    function automatic void model(input int e, output logic v, output logic s, output logic eo,
                                  output logic signed [15:0] re, output logic signed [15:0] im,
                                  output logic sat);
        int j, t;
        longint a, b, c, d;
        logic c1, c2;
        v = 0; s = 0; eo = 0; re = 0; im = 0; sat = 0;
        j = e - (LAT - 1);
        t = j + TWO;
        if (j < 0 || e >= HN) return;
        for (int x = j; x <= e; x++) if (h_rst[x]) return;
        v = h_v[j]; s = h_s[j]; eo = h_e[j];
        a = h_dr[j]; b = h_di[j];
        c = h_sel[j] ? h_t3r[t] : h_t1r[t];
        d = h_sel[j] ? h_t3i[t] : h_t1i[t];
        re  = fix(a * c - b * d, c1);
        im  = fix(a * d + b * c, c2);
        sat = c1 | c2;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        din_valid = 0; din_sop = 0; din_eop = 0; din_sel3 = 0;
        din_real = 16'($urandom); din_imag = 16'($urandom);
    endtask

    task automatic rand_tw();
        tw1_real = 16'($urandom_range(0, 32768) - 16384);
        tw1_imag = 16'($urandom_range(0, 32768) - 16384);
        tw3_real = 16'($urandom_range(0, 32768) - 16384);
        tw3_imag = 16'($urandom_range(0, 32768) - 16384);
    endtask

    task automatic do_reset();
        rst = 1; idle_in(); step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_in(); rand_tw();
        step(); step(); step();
        n_tests++;
        if ({dout_valid, dout_sop, dout_eop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl got %b exp 000", {dout_valid, dout_sop, dout_eop});
        end
        n_tests++;
        if (dout_real !== 16'sd0 || dout_imag !== 16'sd0) begin
            n_fail++; $display("FAIL reset_data got (%0d,%0d) exp (0,0)", dout_real, dout_imag);
        end
        n_tests++;
        if (err_gap !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got err_gap=%b ovf=%b exp 0 0", err_gap, ovf);
        end
        rst = 0;
    endtask

    // Known vectors; each twiddle is placed exactly TWO cycles after its sample.
    task automatic test_directed();
        int t_sel[7] = '{0, 0, 1, 0, 0, 0, 0};
        int t_dr[7]  = '{1000, 1000, 1000, 3, -3, 1, 32767};
        int t_di[7]  = '{-2000, 500, 500, 0, 0, 0, 32767};
        int t_1r[7]  = '{16384, 0, 0, 8192, 8192, 8192, 16384};
        int t_1i[7]  = '{0, -16384, -16384, 0, 0, 0, 16384};
        int t_3r[7]  = '{0, -16384, -16384, 0, 0, 0, 0};
        int t_er[7]  = '{1000, 500, -1000, 2, -1, 1, 0};
`ifdef TWDL_CMULT_SAT_EN
        int t_ei[7]  = '{-2000, -1000, -500, 0, 0, 0, 32767};
        logic exp_ovf = 1'b1;
`else
        int t_ei[7]  = '{-2000, -1000, -500, 0, 0, 0, -2};
        logic exp_ovf = 1'b0;
`endif
        int j;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (c < 7) begin
                din_valid = 1; din_sop = (c == 0); din_eop = (c == 6);
                din_sel3 = (t_sel[c] != 0);
                din_real = 16'(t_dr[c]); din_imag = 16'(t_di[c]);
            end else idle_in();
            if (c >= TWO && c < TWO + 7) begin
                tw1_real = 16'(t_1r[c-TWO]); tw1_imag = 16'(t_1i[c-TWO]);
                tw3_real = 16'(t_3r[c-TWO]); tw3_imag = 16'sd0;
            end else rand_tw();
            step();
            n_tests++;
            if (c >= LAT - 1 && c < LAT + 6) begin
                j = c - (LAT - 1);
                if (dout_valid !== 1'b1 || dout_sop !== (j == 0) || dout_eop !== (j == 6)) begin
                    n_fail++;
                    $display("FAIL dir_ctl c=%0d got v/s/e=%b%b%b exp 1%b%b", c, dout_valid,
                             dout_sop, dout_eop, j == 0, j == 6);
                end
                n_tests++;
                if (dout_real !== 16'(t_er[j]) || dout_imag !== 16'(t_ei[j])) begin
                    n_fail++;
                    $display("FAIL dir_data vec=%0d got (%0d,%0d) exp (%0d,%0d)", j,
                             dout_real, dout_imag, t_er[j], t_ei[j]);
                end
            end else if (dout_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir_idle c=%0d got valid=%b exp 0", c, dout_valid);
            end
            if (c == LAT + 5) begin
                n_tests++;
                if (ovf !== 1'b0) begin n_fail++; $display("FAIL dir_ovf_early got %b exp 0", ovf); end
            end
            if (c == LAT + 6) begin
                n_tests++;
                if (ovf !== exp_ovf) begin
                    n_fail++; $display("FAIL dir_ovf got %b exp %b", ovf, exp_ovf);
                end
            end
        end
        n_tests++;
        if (err_gap !== 1'b0) begin n_fail++; $display("FAIL dir_err_gap got %b exp 0", err_gap); end
    endtask

    // Restart and 1-sample frames are legal; a gap inside a frame is sticky.
    task automatic test_gap();
        stim_t pre[5] = '{'{1, 1, 0}, '{1, 0, 0}, '{1, 1, 0}, '{1, 0, 1}, '{1, 1, 1}};
        int cnt = 0;
        do_reset();
        for (int c = 0; c < 5 + 32; c++) begin
            if (c < 5) begin
                din_valid = pre[c].v; din_sop = pre[c].s; din_eop = pre[c].e;
                din_real = 16'($urandom); din_imag = 16'($urandom);
            end else idle_in();
            rand_tw(); step();
            if (dout_valid === 1'b1) cnt++;
        end
        n_tests++;
        if (cnt != 5) begin n_fail++; $display("FAIL gap_pre_count got %0d exp 5", cnt); end
        n_tests++;
        if (err_gap !== 1'b0) begin n_fail++; $display("FAIL gap_restart got err_gap=%b exp 0", err_gap); end
        cnt = 0;
        for (int c = 0; c < 8 + 32; c++) begin
            if (c < 8) begin
                din_valid = (c != 3); din_sop = (c == 0); din_eop = (c == 7);
                din_real = 16'($urandom); din_imag = 16'($urandom);
            end else idle_in();
            rand_tw(); step();
            if (dout_valid === 1'b1) cnt++;
            if (c == 2 || c == 3) begin
                n_tests++;
                if (err_gap !== (c == 3)) begin
                    n_fail++; $display("FAIL gap_flag c=%0d got %b exp %b", c, err_gap, c == 3);
                end
            end
        end
        n_tests++;
        if (cnt != 7) begin n_fail++; $display("FAIL gap_count got %0d exp 7", cnt); end
        n_tests++;
        if (err_gap !== 1'b1) begin n_fail++; $display("FAIL gap_sticky got %b exp 1", err_gap); end
    endtask

    task automatic test_reset_midframe();
        logic mv, ms, me, msat;
        logic signed [15:0] mre, mim;
        int first = -1;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            din_valid = 1; din_sop = (c == 0); din_eop = 0; din_sel3 = 0;
            din_real = 16'($urandom); din_imag = 16'($urandom);
            rst = (c == 2);
            rand_tw(); step();
        end
        rst = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            idle_in(); rand_tw(); step();
            n_tests++;
            if (dout_valid !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_flush c=%0d got valid=%b exp 0", c, dout_valid);
            end
        end
        for (int c = 0; c < 4 + 32; c++) begin
            if (c < 4) begin
                din_valid = 1; din_sop = (c == 0); din_eop = (c == 3);
                din_sel3 = 1'($urandom);
                din_real = 16'($urandom); din_imag = 16'($urandom);
            end else idle_in();
            rand_tw(); step();
            model(cyc - 1, mv, ms, me, mre, mim, msat);
            if (dout_valid === 1'b1 && first < 0) first = c;
            n_tests++;
            if (dout_valid !== mv || dout_sop !== ms || dout_eop !== me ||
                (mv && (dout_real !== mre || dout_imag !== mim))) begin
                n_fail++;
                $display("FAIL rstmid_frame c=%0d got %b%b%b (%0d,%0d) exp %b%b%b (%0d,%0d)", c,
                         dout_valid, dout_sop, dout_eop, dout_real, dout_imag, mv, ms, me, mre, mim);
            end
        end
        n_tests++;
        if (first != LAT - 1) begin
            n_fail++; $display("FAIL rstmid_latency got %0d exp %0d", first + 1, LAT);
        end
        n_tests++;
        if (err_gap !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_gap got %b exp 0", err_gap); end
    endtask

    // Back-to-back random frames, random sel3, twiddles changing every cycle.
    task automatic test_random();
        stim_t q[$];
        logic mv, ms, me, msat;
        logic signed [15:0] mre, mim;
        logic exp_ovf = 1'b0;
        for (int f = 0; f < 8; f++) begin
            int len = $urandom_range(1, 16);
            int gap = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) q.push_back('{1'b1, i == 0, i == len - 1});
            for (int i = 0; i < gap; i++) q.push_back('{1'b0, 1'b0, 1'b0});
        end
        for (int i = 0; i < LAT + 3; i++) q.push_back('{1'b0, 1'b0, 1'b0});
        do_reset();
        foreach (q[n]) begin
            din_valid = q[n].v; din_sop = q[n].s; din_eop = q[n].e;
            din_sel3 = 1'($urandom);
            din_real = 16'($urandom); din_imag = 16'($urandom);
            rand_tw(); step();
            model(cyc - 1, mv, ms, me, mre, mim, msat);
            n_tests++;
            if (dout_valid !== mv || dout_sop !== ms || dout_eop !== me) begin
                n_fail++;
                $display("FAIL rand_ctl n=%0d got %b%b%b exp %b%b%b", n, dout_valid, dout_sop,
                         dout_eop, mv, ms, me);
            end
            if (mv) begin
                n_tests++;
                if (dout_real !== mre || dout_imag !== mim) begin
                    n_fail++;
                    $display("FAIL rand_data n=%0d got (%0d,%0d) exp (%0d,%0d)", n, dout_real,
                             dout_imag, mre, mim);
                end
            end
            n_tests++;
            if (ovf !== exp_ovf || err_gap !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_flags n=%0d got ovf=%b err_gap=%b exp %b 0", n, ovf, err_gap, exp_ovf);
            end
            if (mv && msat) exp_ovf = 1'b1;
        end
    endtask

    initial begin
        rst = 1; idle_in(); rand_tw();
        test_reset();
        test_directed();
        test_gap();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
